// File: rtl/opa_out_sar_adc.sv
// Behavioural SAR ADC on the amplifier output net: tracks vin for P_SAMPLE_CYC
// edges, then resolves N_BITS MSB-first against a real-valued DAC.
module opa_out_sar_adc #(
  parameter int  N_BITS        = 10,
  parameter int  P_SAMPLE_CYC  = 4,
  parameter real p_Vt_3P3V     = 1.75,
  parameter real p_Vt_VSS      = 0.1,
  parameter real WREAL_Z_STATE = 1.0e30,
  parameter real WREAL_X_STATE = -1.0e30
) (
  input  logic              clk_i_3P3V,
  input  logic              rst_i_3P3V,
  input  real               AVDD_3P3V,
  input  real               AVSS,
  input  real               vin_a_3P3V,
  input  real               vref_a_3P3V,
  input  logic              en_i_3P3V,
  input  logic              start_i_3P3V,
  output logic              busy_o_3P3V,
  output logic              done_o_3P3V,
  output logic [N_BITS-1:0] code_o_3P3V,
  output logic              ovr_o_3P3V,
  output logic              invld_o_3P3V
);

  localparam int  BW         = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam real FULL_SCALE = 2.0 ** N_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } state_t;

  // Z and X wreal states are modelled as sentinel real values.
  function automatic logic is_bad(input real v);
    return (v == WREAL_Z_STATE) || (v == WREAL_X_STATE);
  endfunction

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [BW-1:0]     bit_idx, bit_n;
  logic [N_BITS-1:0] acc, acc_n;
  real               vin_held, vin_held_n;
  logic              busy_n, done_n, ovr_n, invld_n;
  logic [N_BITS-1:0] code_n;

  logic              power_ok;
  logic              abort;
  logic [N_BITS-1:0] bit_mask;
  logic [N_BITS-1:0] trial_word;
  logic [N_BITS-1:0] resolved;
  real               vdac;
  logic              keep;
  logic              vin_bad;
  logic              ref_bad;

  assign power_ok   = (AVDD_3P3V > p_Vt_3P3V) && (AVSS < p_Vt_VSS);
  assign abort      = !en_i_3P3V || !power_ok;
  assign bit_mask   = {{(N_BITS-1){1'b0}}, 1'b1} << bit_idx;
  assign trial_word = acc | bit_mask;
  assign vdac       = AVSS + real'(trial_word) * (vref_a_3P3V - AVSS) / FULL_SCALE;
  assign keep       = (vin_held >= vdac);
  assign resolved   = keep ? trial_word : acc;
  assign vin_bad    = is_bad(vin_held);
  assign ref_bad    = is_bad(vref_a_3P3V) || (vref_a_3P3V <= AVSS);

  // State, datapath and output registers.
  always_ff @(posedge clk_i_3P3V or posedge rst_i_3P3V) begin
    if (rst_i_3P3V) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      bit_idx      <= '0;
      acc          <= '0;
      vin_held     <= 0.0;
      busy_o_3P3V  <= 1'b0;
      done_o_3P3V  <= 1'b0;
      code_o_3P3V  <= '0;
      ovr_o_3P3V   <= 1'b0;
      invld_o_3P3V <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_n;
      acc          <= acc_n;
      vin_held     <= vin_held_n;
      busy_o_3P3V  <= busy_n;
      done_o_3P3V  <= done_n;
      code_o_3P3V  <= code_n;
      ovr_o_3P3V   <= ovr_n;
      invld_o_3P3V <= invld_n;
    end
  end

  // Next-state, bit resolution and completion outcome.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    acc_n      = acc;
    vin_held_n = vin_held;
    busy_n     = busy_o_3P3V;
    done_n     = 1'b0;
    code_n     = code_o_3P3V;
    ovr_n      = ovr_o_3P3V;
    invld_n    = invld_o_3P3V;
    case (state)
      IDLE: begin
        if (start_i_3P3V && en_i_3P3V && power_ok) begin
          state_n = SAMPLE;
          cnt_n   = 4'(P_SAMPLE_CYC - 1);
          busy_n  = 1'b1;
        end else begin
          busy_n  = 1'b0;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          vin_held_n = vin_a_3P3V;
          if (cnt == 4'd0) begin
            state_n = CONVERT;
            bit_n   = BW'(N_BITS - 1);
            acc_n   = '0;
          end else begin
            cnt_n   = cnt - 4'd1;
          end
        end
      end
      CONVERT: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          acc_n = resolved;
          if (bit_idx == '0) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            // Invalid input or reference overrides any range indication.
            if (vin_bad || ref_bad) begin
              code_n  = '0;
              ovr_n   = 1'b0;
              invld_n = 1'b1;
            end else if (vin_held >= vref_a_3P3V) begin
              code_n  = {N_BITS{1'b1}};
              ovr_n   = 1'b1;
              invld_n = 1'b0;
            end else if (vin_held < AVSS) begin
              code_n  = '0;
              ovr_n   = 1'b1;
              invld_n = 1'b0;
            end else begin
              code_n  = resolved;
              ovr_n   = 1'b0;
              invld_n = 1'b0;
            end
          end else begin
            bit_n = bit_idx - BW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_opa_out_sar_adc.sv
// Scoreboard bench for opa_out_sar_adc: expected codes come from an ideal
// quantiser model; a monitor pops and compares on every done pulse.
module tb_opa_out_sar_adc;

  localparam int  NB      = 10;
  localparam int  LAT     = 14;
  localparam real Z_STATE = 1.0e30;
  localparam real X_STATE = -1.0e30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic start = 1'b0;
  real  avdd = 3.3;
  real  avss = 0.0;
  real  vin  = 0.0;
  real  vref = 2.0;
  logic busy, done, ovr, invld;
  logic [NB-1:0] code;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_code = 0;

  typedef struct {
    int code;
    int ovr;
    int invld;
    int start_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  opa_out_sar_adc dut (
    .clk_i_3P3V  (clk),
    .rst_i_3P3V  (rst),
    .AVDD_3P3V   (avdd),
    .AVSS        (avss),
    .vin_a_3P3V  (vin),
    .vref_a_3P3V (vref),
    .en_i_3P3V   (en),
    .start_i_3P3V(start),
    .busy_o_3P3V (busy),
    .done_o_3P3V (done),
    .code_o_3P3V (code),
    .ovr_o_3P3V  (ovr),
    .invld_o_3P3V(invld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic bit bad(input real v);
    return (v == Z_STATE) || (v == X_STATE);
  endfunction

  // Ideal quantiser: floor of the input as a fraction of the reference span.
  task automatic model(input real v, input real vr, input real vs, output exp_t e);
    e.start_edge = 0;
    if (bad(v) || bad(vr) || vr <= vs) begin
      e.code = 0; e.ovr = 0; e.invld = 1;
    end else if (v >= vr) begin
      e.code = (1 << NB) - 1; e.ovr = 1; e.invld = 0;
    end else if (v < vs) begin
      e.code = 0; e.ovr = 1; e.invld = 0;
    end else begin
      e.code = int'($floor((v - vs) / (vr - vs) * real'(1 << NB)));
      e.ovr = 0; e.invld = 0;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("code", int'(code), mon_e.code);
        chk("ovr", int'(ovr), mon_e.ovr);
        chk("invld", int'(invld), mon_e.invld);
        chk("latency", cyc - mon_e.start_edge, LAT);
      end
    end
  end

  // Issue one conversion from a negedge; returns at the negedge that shows done.
  // Spurious starts while busy and a moving vin after the hold are injected.
  task automatic run_conv(input real v, input real vr);
    exp_t e;
    int   nbusy;
    bit   seen;
    model(v, vr, avss, e);
    e.start_edge = cyc + 1;
    sb.push_back(e);
    last_code = e.code;
    vin   = v;
    vref  = vr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) nbusy++;
        if (i == 4) vin = real'($urandom_range(0, 2000)) / 1000.0;
        start = (i < 13) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_seen", int'(seen), 1);
    chk("busy_cycles", nbusy, LAT);
  endtask

  initial begin
    int nb;
    real rv;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_invld", int'(invld), 0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(1.0, 2.0);
    repeat (2) @(negedge clk);
    run_conv(0.5, 2.0);
    run_conv(0.5, 2.0);
    @(negedge clk);
    run_conv(2.5, 2.0);
    run_conv(-0.2, 2.0);
    run_conv(Z_STATE, 2.0);
    run_conv(1.5, 2.0);
    run_conv(X_STATE, 2.0);
    run_conv(1.0, 0.0);
    run_conv(2.0, 2.0);
    run_conv(1.5, 2.0);
    @(negedge clk);

    // Abort by dropping enable just before the third CONVERT edge.
    vin = 1.0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("abort_code_kept", int'(code), last_code);
    en = 1'b1;
    @(negedge clk);

    // Asynchronous reset between edges mid-SAMPLE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_code", int'(code), 0);
    chk("arst_ovr", int'(ovr), 0);
    chk("arst_invld", int'(invld), 0);
    @(negedge clk);
    rst = 1'b0;
    run_conv(1.0, 2.0);
    @(negedge clk);

    // Supply below threshold: start must be ignored.
    avdd = 1.5;
    start = 1'b1;
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nb++;
    end
    chk("lowsupply_busy", nb, 0);
    avdd = 3.3;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      rv = real'($urandom_range(0, 4400)) / 2000.0 - 0.1;
      case ($urandom_range(0, 3))
        0: vref = 1.0;
        1: vref = 4.0;
        default: vref = 2.0;
      endcase
      run_conv(rv, vref);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
